// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: requester and response handshake bundle for the shared-ALU controller
interface alu_share_ctrl_if #(parameter int W = 4);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [3:0]   req0_op;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [3:0]   req1_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_res;
  logic         rsp_err;
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_res, rsp_err
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_res, rsp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one 4-bit combinational ALU between two requesters
module alu_share_ctrl #(
  parameter int           W        = 4,
  parameter logic [W-1:0] DIV0_RES = '0,
  parameter int           CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_ctrl_if.slave  bus,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [3:0]       alu_s,
  input  logic [W-1:0]     alu_res,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q;
  logic   ptr_q;
  logic   gnt1, gnt0, div0;
  // req1 wins when alone or when the pointer favours it and both are asking
  assign gnt1 = bus.req1_valid && (!bus.req0_valid || ptr_q);
  assign gnt0 = bus.req0_valid && !gnt1;
  assign bus.req0_ready = (state_q == IDLE) && gnt0;
  assign bus.req1_ready = (state_q == IDLE) && gnt1;
  assign busy = state_q != IDLE;
  assign div0 = (alu_s == 4'b0011 || alu_s == 4'b1011) && alu_b == '0;
  // accept, let the ALU settle for one cycle, then hold the response until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_s         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_res   <= '0;
      bus.rsp_err   <= 1'b0;
      op_cnt        <= '0;
      err_cnt       <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt0 || gnt1) begin
          alu_a      <= gnt1 ? bus.req1_a : bus.req0_a;
          alu_b      <= gnt1 ? bus.req1_b : bus.req0_b;
          alu_s      <= gnt1 ? bus.req1_op : bus.req0_op;
          bus.rsp_id <= gnt1;
          state_q    <= EXEC;
        end
        EXEC: begin
          bus.rsp_err   <= div0;
          bus.rsp_res   <= div0 ? DIV0_RES : alu_res;
          bus.rsp_valid <= 1'b1;
          state_q       <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          op_cnt        <= op_cnt + CNT_W'(1);
          err_cnt       <= err_cnt + CNT_W'(bus.rsp_err);
          ptr_q         <= !bus.rsp_id;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed-vector bench for the shared-ALU controller
module tb_alu_share_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alu_a, alu_b, alu_s, alu_res;
  logic       busy;
  logic [7:0] op_cnt, err_cnt;
  int         n_vec = 0;
  int         n_err = 0;
  alu_share_ctrl_if #(.W(4)) ifc ();
  alu_share_ctrl #(.W(4), .DIV0_RES(4'h0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_res(alu_res),
    .busy(busy), .op_cnt(op_cnt), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  // reference ALU; divide/modulo by zero yields F so a leak is visible
  always_comb begin
    alu_res = alu_a ^ alu_b;
    case (alu_s)
      4'b0000: alu_res = alu_a + alu_b;
      4'b0001: alu_res = alu_a - alu_b;
      4'b0010: alu_res = alu_a * alu_b;
      4'b0011: alu_res = (alu_b == 0) ? 4'hF : alu_a / alu_b;
      4'b1011: alu_res = (alu_b == 0) ? 4'hF : alu_a % alu_b;
      4'b1100: alu_res = alu_a + 4'd1;
      4'b1101: alu_res = alu_a - 4'd1;
      default: alu_res = alu_a ^ alu_b;
    endcase
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    int n = 0;
    if (id) begin
      ifc.req1_a = a; ifc.req1_b = b; ifc.req1_op = op; ifc.req1_valid = 1'b1;
    end else begin
      ifc.req0_a = a; ifc.req0_b = b; ifc.req0_op = op; ifc.req0_valid = 1'b1;
    end
    #1;
    while (!(id ? ifc.req1_ready : ifc.req0_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant", 32'(n < 20), 1);
    @(posedge clk);
    #1;
    if (id) ifc.req1_valid = 1'b0;
    else ifc.req0_valid = 1'b0;
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ifc.rsp_valid && lat < 20);
    chk("rsp_seen", 32'(ifc.rsp_valid), 1);
  endtask
  task automatic run_op(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic [3:0] res, input bit err);
    int lat;
    ifc.rsp_ready = 1'b1;
    issue(id, a, b, op);
    wait_rsp(lat);
    chk("latency", lat, 2);
    chk("rsp_id", 32'(ifc.rsp_id), 32'(id));
    chk("rsp_res", 32'(ifc.rsp_res), 32'(res));
    chk("rsp_err", 32'(ifc.rsp_err), 32'(err));
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    int lat;
    bit sid;
    logic [3:0] sres;
    ifc.req0_valid = 0; ifc.req0_a = 0; ifc.req0_b = 0; ifc.req0_op = 0;
    ifc.req1_valid = 0; ifc.req1_a = 0; ifc.req1_b = 0; ifc.req1_op = 0;
    ifc.rsp_ready = 0;
    @(negedge clk);
    do_reset();
    chk("rst_alu", {alu_a, alu_b, alu_s}, 0);
    chk("rst_rsp", {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_res, ifc.rsp_err}, 0);
    chk("rst_cnt", {op_cnt, err_cnt}, 0);
    chk("rst_busy", 32'(busy), 0);
    run_op(0, 4'd3, 4'd5, 4'b0000, 4'd8, 0);
    chk("op_cnt1", op_cnt, 1);
    run_op(1, 4'd2, 4'd5, 4'b0001, 4'hD, 0);
    run_op(0, 4'd5, 4'd5, 4'b0010, 4'd9, 0);
    run_op(1, 4'd0, 4'd0, 4'b1101, 4'hF, 0);
    // both requesters held valid: grants must alternate starting from req0
    do_reset();
    ifc.req0_a = 4'd2; ifc.req0_b = 4'd3; ifc.req0_op = 4'b0010; ifc.req0_valid = 1;
    ifc.req1_a = 4'hF; ifc.req1_b = 4'd0; ifc.req1_op = 4'b1100; ifc.req1_valid = 1;
    ifc.rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(lat);
      chk("rr_id", 32'(ifc.rsp_id), 32'(k % 2));
      chk("rr_res", 32'(ifc.rsp_res), (k % 2) ? 0 : 6);
      @(posedge clk);
      @(negedge clk);
    end
    ifc.req0_valid = 0; ifc.req1_valid = 0;
    repeat (4) @(negedge clk);
    // divide and modulo by zero
    do_reset();
    run_op(1, 4'd7, 4'd0, 4'b0011, 4'd0, 1);
    run_op(1, 4'd9, 4'd0, 4'b1011, 4'd0, 1);
    chk("err_cnt2", err_cnt, 2);
    run_op(0, 4'd9, 4'd2, 4'b0011, 4'd4, 0);
    run_op(1, 4'd9, 4'd4, 4'b1011, 4'd1, 0);
    chk("err_cnt_hold", err_cnt, 2);
    chk("op_cnt4", op_cnt, 4);
    // back-pressure with both valid
    do_reset();
    ifc.req0_a = 4'd5; ifc.req0_b = 4'd5; ifc.req0_op = 4'b0010; ifc.req0_valid = 1;
    ifc.req1_a = 4'd2; ifc.req1_b = 4'd5; ifc.req1_op = 4'b0001; ifc.req1_valid = 1;
    ifc.rsp_ready = 0;
    wait_rsp(lat);
    sid = ifc.rsp_id;
    sres = ifc.rsp_res;
    chk("bp_id", 32'(sid), 0);
    chk("bp_res", 32'(sres), 9);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_hold", {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_res, ifc.rsp_err}, {1'b1, 1'b0, 4'd9, 1'b0});
      chk("bp_ready", {ifc.req0_ready, ifc.req1_ready}, 0);
      chk("bp_busy", 32'(busy), 1);
    end
    ifc.rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("bp_next", {busy, ifc.rsp_valid, ifc.req0_ready, ifc.req1_ready}, 4'b0001);
    ifc.req0_valid = 0; ifc.req1_valid = 0;
    @(negedge clk);
    // reset while the operation sits in EXEC
    do_reset();
    issue(0, 4'd4, 4'd6, 4'b0000);
    chk("exec_busy", 32'(busy), 1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rexec_out", {alu_a, alu_b, alu_s, ifc.rsp_valid, ifc.rsp_id, ifc.rsp_res, ifc.rsp_err, busy}, 0);
    chk("rexec_cnt", {op_cnt, err_cnt}, 0);
    lat = 0;
    repeat (6) begin
      @(negedge clk);
      lat += 32'(ifc.rsp_valid);
    end
    chk("rexec_norsp", lat, 0);
    // counter wrap after 256 deliveries
    for (int i = 0; i < 256; i++) begin
      run_op(0, 4'(i), 4'd1, 4'b0000, 4'(i + 1), 0);
      if (i == 254) chk("op_cnt255", op_cnt, 255);
    end
    chk("op_cnt_wrap", op_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Arbitration and sequencing controller that shares one 4-bit combinational ALU between two requesters.
- Accepts operations from either requester over a valid/ready handshake and grants them round-robin.
- Drives registered operands and opcode to the ALU, then captures the result and returns it on one tagged response channel.
- Detects divide/modulo by zero so that an undefined ALU result never reaches a requester.

Parameters:
- W, 4: operand/result width; fixed at 4 to match the shared ALU.
- DIV0_RES, 4'h0: value returned on rsp_res when a divide or modulo by zero is flagged.
- CNT_W, 8: width of the completed-operation and error counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  W each  requester 0 operands.
- req0_op  in  4  requester 0 ALU opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above, for requester 1.
- alu_a, alu_b  out  W each  registered operands driven to the ALU.
- alu_s  out  4  registered opcode driven to the ALU.
- alu_res  in  W  ALU result, combinational from alu_a/alu_b/alu_s.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the operation (0 or 1).
- rsp_res  out  W  captured result.
- rsp_err  out  1  divide or modulo by zero detected.
- busy  out  1  state is not IDLE.
- op_cnt  out  CNT_W  responses delivered, wraps modulo 2^CNT_W.
- err_cnt  out  CNT_W  responses delivered with rsp_err=1, wraps.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE, round-robin pointer favours req0.
  - All outputs 0: alu_a/alu_b/alu_s, rsp_*, op_cnt, err_cnt, busy.
  - Reset overrides any in-flight operation; the operation is discarded and no response is issued.
- Ready generation: reqN_ready = (state==IDLE) && grantN && reqN_valid. It is combinational from state, pointer and valids, and at most one ready is high per cycle.
- Grant, in IDLE:
  - Only one valid high: that requester is granted.
  - Both valid: the pointer's requester is granted.
  - Neither valid: stay in IDLE.
- States:
  - IDLE: on a handshake, latch the granted reqN_a/b/op into alu_a/alu_b/alu_s, latch id, go to EXEC.
  - EXEC (1 cycle):
    - Capture rsp_res=alu_res.
    - If alu_s is 4'b0011 or 4'b1011 and alu_b==0: rsp_err=1 and rsp_res=DIV0_RES; otherwise rsp_err=0.
    - Set rsp_valid=1, go to RESP.
  - RESP:
    - Hold rsp_valid/id/res/err stable until rsp_valid && rsp_ready.
    - On acceptance: rsp_valid=0, op_cnt+=1, err_cnt+=rsp_err, pointer set to the requester other than rsp_id, go to IDLE.
- Timing:
  - Latency: accept edge to rsp_valid high is 2 clocks.
  - Minimum issue interval is 3 clocks; there is no overlap or pipelining.
- Operands and results:
  - alu_a/alu_b/alu_s remain at their last values outside EXEC.
  - Result width is truncated to W, as the ALU delivers it. The controller does not modify non-error results: wrap-around on add, sub, mul, inc, dec and pow passes through unchanged.
- Requester rules:
  - A requester may drop valid before ready with no effect.
  - Operands are sampled only on the handshake edge.
  - Requests arriving while busy wait; no request is queued internally.
- Counter wrap: op_cnt and err_cnt roll over from 2^CNT_W-1 to 0.

Test Plan:
- After reset, req0 a=3,b=5,op=0000 -> req0_ready high 1 cycle; rsp_valid 2 clocks later with rsp_id=0, rsp_res=8, rsp_err=0; op_cnt=1 after acceptance.
- req0 and req1 valid together from reset, req0 a=2,b=3,op=0010 and req1 a=4'hF,op=1100 -> req0 served first (res=6), then req1 (res=0, wrap-around); with both still valid, grants alternate 0,1,0,1.
- req1 a=7,b=0,op=0011, then a=9,b=0,op=1011 -> both responses rsp_err=1, rsp_res=DIV0_RES; err_cnt=2.
- rsp_ready held low 5 cycles with both valids high -> rsp_valid/id/res/err stable throughout, no readys asserted, busy=1; release -> next grant in the following IDLE cycle.
- rst asserted during EXEC -> next cycle all outputs 0 and state IDLE; the discarded operation never produces rsp_valid.
- 256 accepted operations with CNT_W=8 -> op_cnt wraps to 0.
